usb_fs_out_ep_arb: RTL and testbench

Arbiter that shares the OUT protocol engine's single endpoint read port (`out_ep_data`, `out_ep_data_get`, `out_ep_grant`) between up to 16 endpoint consumers. It sits between the per-endpoint consumer logic and the OUT protocol engine. It issues a registered one-hot grant, gates each consumer's get strobes onto the engine's `out_ep_data_get` bus, and revokes a grant that stalls without data.

---
 rtl/usb_fs_out_ep_arb.sv | 147 ++++++++++++++
 tb/tb_usb_fs_out_ep_arb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_out_ep_arb.sv
// Shares the OUT engine's single endpoint read port among NUM_OUT_EPS consumers: registered one-hot grant, gated gets, stall timeout.
// Grant 1 cycle after request in IDLE, one-cycle RELEASE gap; define USB_OUT_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module usb_fs_out_ep_arb #(
   parameter int NUM_OUT_EPS  = 1,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_OUT_EPS-1:0] out_ep_req,
   input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
   input  logic [NUM_OUT_EPS-1:0] ep_data_get,
   output logic [NUM_OUT_EPS-1:0] out_ep_grant,
   output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
   output logic [3:0]             grant_ep,
   output logic                   grant_valid,
   output logic                   arb_timeout
);
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;

   localparam logic [7:0] TMO = 8'(IDLE_TIMEOUT);

   state_t                 state_q, state_d;
   logic [NUM_OUT_EPS-1:0] grant_q, grant_d;
   logic [3:0]             grant_ep_q, grant_ep_d;
   logic [7:0]             stall_q, stall_d, stall_nxt;
   logic                   tmo_q, tmo_d;
   logic [NUM_OUT_EPS-1:0] sel;
   logic                   req_win, avail_win, get_win;

   function automatic logic [NUM_OUT_EPS-1:0] lowest_f(input logic [NUM_OUT_EPS-1:0] v);
      lowest_f = '0;
      for (int i = NUM_OUT_EPS-1; i >= 0; i--) begin
         if (v[i]) begin
            lowest_f    = '0;
            lowest_f[i] = 1'b1;
         end
      end
   endfunction

   function automatic logic [3:0] enc_f(input logic [NUM_OUT_EPS-1:0] v);
      enc_f = 4'd0;
      for (int i = 0; i < NUM_OUT_EPS; i++) begin
         if (v[i]) enc_f = 4'(i);
      end
   endfunction

`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
   logic [NUM_OUT_EPS-1:0] last_q, last_d;
   logic [NUM_OUT_EPS-1:0] mask_hi, req_hi;

   // mask_hi covers the endpoints strictly above the last winner; wrap falls back to the full request set
   always_comb begin : rr_sel
      logic seen;
      seen    = 1'b0;
      mask_hi = '0;
      for (int i = 0; i < NUM_OUT_EPS; i++) begin
         mask_hi[i] = seen;
         if (last_q[i]) seen = 1'b1;
      end
      req_hi = out_ep_req & mask_hi;
      sel    = (|req_hi) ? lowest_f(req_hi) : lowest_f(out_ep_req);
   end
`else
   always_comb sel = lowest_f(out_ep_req);
`endif

   assign out_ep_grant    = grant_q;
   assign grant_ep        = grant_ep_q;
   assign grant_valid     = (state_q == GRANT);
   assign arb_timeout     = tmo_q;
   assign out_ep_data_get = ep_data_get & grant_q & {NUM_OUT_EPS{state_q == GRANT}};

   // grant_q is one-hot on the winner, so masking with it selects the winner's bit
   assign req_win   = |(out_ep_req & grant_q);
   assign avail_win = |(out_ep_data_avail & grant_q);
   assign get_win   = |out_ep_data_get;

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      grant_ep_d = grant_ep_q;
      stall_d    = stall_q;
      tmo_d      = 1'b0;
`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      stall_nxt  = stall_q;
      if (get_win)
         stall_nxt = 8'd0;
      else if (!avail_win && stall_q != 8'hFF)
         stall_nxt = stall_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (|out_ep_req) begin
               state_d    = GRANT;
               grant_d    = sel;
               grant_ep_d = enc_f(sel);
               stall_d    = 8'd0;
`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
               last_d     = sel;
`endif
            end
         end
         GRANT: begin
            if (!req_win || stall_nxt >= TMO) begin
               state_d    = RELEASE;
               grant_d    = '0;
               grant_ep_d = 4'd0;
               stall_d    = 8'd0;
               tmo_d      = req_win;
            end else begin
               stall_d = stall_nxt;
            end
         end
         RELEASE: state_d = IDLE;
         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_ep_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_ep_q <= 4'd0;
         stall_q    <= 8'd0;
         tmo_q      <= 1'b0;
`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
         last_q     <= '0;
         last_q[NUM_OUT_EPS-1] <= 1'b1;
`endif
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         grant_ep_q <= grant_ep_d;
         stall_q    <= stall_d;
         tmo_q      <= tmo_d;
`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
         last_q     <= last_d;
`endif
      end
   end
endmodule

// File: tb/tb_usb_fs_out_ep_arb.sv
// Bench for usb_fs_out_ep_arb: 4 endpoints, IDLE_TIMEOUT = 8; expected grants queued at stimulus time.
module tb_usb_fs_out_ep_arb;
   localparam int N   = 4;
   localparam int TMO = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] out_ep_req = '0;
   logic [N-1:0] out_ep_data_avail = '0;
   logic [N-1:0] ep_data_get = '0;
   logic [N-1:0] out_ep_grant;
   logic [N-1:0] out_ep_data_get;
   logic [3:0]   grant_ep;
   logic         grant_valid;
   logic         arb_timeout;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];
   logic       gv_prev = 1'b0;

   usb_fs_out_ep_arb #(.NUM_OUT_EPS(N), .IDLE_TIMEOUT(TMO)) dut (
      .clk(clk), .reset_n(reset_n),
      .out_ep_req(out_ep_req), .out_ep_data_avail(out_ep_data_avail), .ep_data_get(ep_data_get),
      .out_ep_grant(out_ep_grant), .out_ep_data_get(out_ep_data_get),
      .grant_ep(grant_ep), .grant_valid(grant_valid), .arb_timeout(arb_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] g, input logic [3:0] e);
      exp_q.push_back({e, g});
   endtask

   // Scoreboard: every new grant must match the next queued expectation
   always @(negedge clk) begin
      if (grant_valid && !gv_prev) begin
         if (exp_q.size() == 0)
            chk("sb_unexpected", {24'd0, grant_ep, out_ep_grant}, 32'd0);
         else
            chk("sb_grant", {24'd0, grant_ep, out_ep_grant}, {24'd0, exp_q.pop_front()});
      end
      gv_prev = grant_valid;
   end

   initial begin
      int order[4];
      logic [3:0] g;
`ifdef USB_OUT_ARB_ROUND_ROBIN_EN
      order = '{1, 2, 1, 2};
`else
      order = '{1, 1, 1, 1};
`endif
      ep_data_get = 4'b1111;
      #2;
      chk("rst_grant", out_ep_grant, 0);
      chk("rst_get", out_ep_data_get, 0);
      chk("rst_ep", grant_ep, 0);
      chk("rst_valid", grant_valid, 0);
      chk("rst_tmo", arb_timeout, 0);
      step();
      step();
      reset_n = 1'b1;
      ep_data_get = 4'b0000;
      step();

      // single request, get gating, release gap
      out_ep_req = 4'b0100;
      push(4'b0100, 4'd2);
      step();
      chk("s1_grant", out_ep_grant, 4'b0100);
      chk("s1_ep", grant_ep, 2);
      chk("s1_valid", grant_valid, 1);
      ep_data_get = 4'b1111;
      #1 chk("s1_get", out_ep_data_get, 4'b0100);
      out_ep_req = 4'b0000;
      #1 chk("drop_get", out_ep_data_get, 4'b0100);
      step();
      chk("s1_rel_grant", out_ep_grant, 0);
      chk("rel_get", out_ep_data_get, 0);
      chk("s1_rel_valid", grant_valid, 0);
      step();
      chk("s1_idle_grant", out_ep_grant, 0);
      step();

      // EP3 gating, then asynchronous reset mid-grant
      out_ep_req = 4'b1000;
      push(4'b1000, 4'd3);
      step();
      chk("ep3_get", out_ep_data_get, 4'b1000);
      chk("ep3_ep", grant_ep, 3);
      step();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_grant", out_ep_grant, 0);
      chk("arst_get", out_ep_data_get, 0);
      chk("arst_ep", grant_ep, 0);
      chk("arst_valid", grant_valid, 0);
      chk("arst_tmo", arb_timeout, 0);
      @(negedge clk);
      reset_n = 1'b1;
      out_ep_req = 4'b1001;
      push(4'b0001, 4'd0);
      step();
      chk("rst_prio", out_ep_grant, 4'b0001);
      ep_data_get = 4'b0000;
      out_ep_req = 4'b0000;
      step();
      step();

      // two requesters, holder drops and re-requests each round
      out_ep_data_avail = 4'b1111;
      ep_data_get = 4'b1111;
      out_ep_req = 4'b0110;
      for (int r = 0; r < 4; r++) begin
         g = 4'b0001 << order[r];
         push(g, 4'(order[r]));
         step();
         chk("s2_grant", out_ep_grant, g);
         step();
         step();
         out_ep_req = 4'b0110 & ~g;
         step();
         chk("s2_rel", out_ep_grant, 0);
         out_ep_req = 4'b0110;
         step();
         chk("s2_idle", out_ep_grant, 0);
      end
      out_ep_req = 4'b0000;
      step();
      step();
      ep_data_get = 4'b0000;
      out_ep_data_avail = 4'b0000;

      // stall timeout
      out_ep_req = 4'b0001;
      push(4'b0001, 4'd0);
      step();
      chk("s3_grant", out_ep_grant, 4'b0001);
      for (int k = 1; k < TMO; k++) begin
         step();
         chk("s3_hold", out_ep_grant, 4'b0001);
         chk("s3_no_tmo", arb_timeout, 0);
      end
      step();
      chk("s3_tmo", arb_timeout, 1);
      chk("s3_drop", out_ep_grant, 0);
      out_ep_req = 4'b0000;
      step();
      chk("s3_pulse_end", arb_timeout, 0);
      step();

      // request drop coincident with timeout
      out_ep_req = 4'b0001;
      push(4'b0001, 4'd0);
      step();
      chk("s6_grant", out_ep_grant, 4'b0001);
      for (int k = 1; k < TMO; k++) step();
      out_ep_req = 4'b0000;
      step();
      chk("s6_rel", out_ep_grant, 0);
      chk("s6_no_tmo", arb_timeout, 0);
      out_ep_req = 4'b0001;
      push(4'b0001, 4'd0);
      step();
      chk("s6_gap", out_ep_grant, 0);
      chk("s6_gap_tmo", arb_timeout, 0);
      step();
      chk("s6_regrant", out_ep_grant, 4'b0001);
      out_ep_req = 4'b0000;
      step();
      step();

      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
